// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_if : datapath request/response and RAM bus bundle for          |
// |                  mem_arbiter. Revision 1.0                                  |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              halt;
   logic              imemREN;
   logic [ADDR_W-1:0] imemaddr;
   logic              ihit;
   logic [DATA_W-1:0] imemload;
   logic              dmemREN;
   logic              dmemWEN;
   logic [ADDR_W-1:0] dmemaddr;
   logic [DATA_W-1:0] dmemstore;
   logic              dhit;
   logic [DATA_W-1:0] dmemload;
   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [DATA_W-1:0] ramstore;
   logic [DATA_W-1:0] ramload;
   logic              ramrdy;

   // slave = the arbiter; master = datapath plus RAM model around it
   modport slave (
      input  halt, imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
             ramload, ramrdy,
      output ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore
   );
   modport master (
      output halt, imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
             ramload, ramrdy,
      input  ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter : serialises fetch and data requests onto one RAM port with    |
// |               fetch/data fairness. Optional MEM_ARB_IBUF_EN: 1-entry ibuf. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic         CLK,
   input  logic         nRST,
   mem_arbiter_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DACC  = 3'd1,
      IACC  = 3'd2,
      DRESP = 3'd3,
      IRESP = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              wr_q, wr_d;
   logic              ifair_q, ifair_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] store_q, store_d;
   logic [DATA_W-1:0] imemload_q, imemload_d;
   logic [DATA_W-1:0] dmemload_q, dmemload_d;
   logic              w_dreq;
   logic              w_ielig;
`ifdef MEM_ARB_IBUF_EN
   logic              ibuf_valid_q, ibuf_valid_d;
   logic [ADDR_W-1:0] ibuf_tag_q, ibuf_tag_d;
   logic [DATA_W-1:0] ibuf_data_q, ibuf_data_d;
`endif

   assign w_dreq  = bus.dmemREN | bus.dmemWEN;
   assign w_ielig = bus.imemREN & ~bus.halt;

   always_comb begin
      state_d    = state_q;
      wr_d       = wr_q;
      ifair_d    = ifair_q;
      addr_d     = addr_q;
      store_d    = store_q;
      imemload_d = imemload_q;
      dmemload_d = dmemload_q;
`ifdef MEM_ARB_IBUF_EN
      ibuf_valid_d = ibuf_valid_q;
      ibuf_tag_d   = ibuf_tag_q;
      ibuf_data_d  = ibuf_data_q;
`endif
      case (state_q)
         IDLE: begin
            if (w_dreq && (!w_ielig || !ifair_q)) begin
               // simultaneous REN and WEN resolves to a write
               state_d = DACC;
               wr_d    = bus.dmemWEN;
               addr_d  = bus.dmemaddr;
               store_d = bus.dmemstore;
            end else if (w_ielig) begin
               state_d = IACC;
               wr_d    = 1'b0;
               addr_d  = bus.imemaddr;
`ifdef MEM_ARB_IBUF_EN
               if (ibuf_valid_q && (bus.imemaddr == ibuf_tag_q)) begin
                  state_d    = IRESP;
                  imemload_d = ibuf_data_q;
               end
`endif
            end
         end
         DACC: begin
            if (bus.ramrdy) begin
               state_d = DRESP;
               if (!wr_q) begin
                  dmemload_d = bus.ramload;
               end
`ifdef MEM_ARB_IBUF_EN
               if (wr_q && (addr_q == ibuf_tag_q)) begin
                  ibuf_valid_d = 1'b0;
               end
`endif
            end
         end
         IACC: begin
            if (bus.ramrdy) begin
               state_d    = IRESP;
               imemload_d = bus.ramload;
            end
         end
         DRESP: begin
            state_d = IDLE;
            if (w_ielig) begin
               ifair_d = 1'b1;
            end
         end
         IRESP: begin
            state_d = IDLE;
            ifair_d = 1'b0;
`ifdef MEM_ARB_IBUF_EN
            ibuf_valid_d = 1'b1;
            ibuf_tag_d   = addr_q;
            ibuf_data_d  = imemload_q;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         wr_q       <= 1'b0;
         ifair_q    <= 1'b0;
         addr_q     <= '0;
         store_q    <= '0;
         imemload_q <= '0;
         dmemload_q <= '0;
`ifdef MEM_ARB_IBUF_EN
         ibuf_valid_q <= 1'b0;
         ibuf_tag_q   <= '0;
         ibuf_data_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         ifair_q    <= ifair_d;
         addr_q     <= addr_d;
         store_q    <= store_d;
         imemload_q <= imemload_d;
         dmemload_q <= dmemload_d;
`ifdef MEM_ARB_IBUF_EN
         ibuf_valid_q <= ibuf_valid_d;
         ibuf_tag_q   <= ibuf_tag_d;
         ibuf_data_q  <= ibuf_data_d;
`endif
      end
   end

   // enables decode from state so an async reset drops them at once
   assign bus.ramREN   = (state_q == IACC) || ((state_q == DACC) && !wr_q);
   assign bus.ramWEN   = (state_q == DACC) && wr_q;
   assign bus.ramaddr  = addr_q;
   assign bus.ramstore = store_q;
   assign bus.ihit     = (state_q == IRESP);
   assign bus.dhit     = (state_q == DRESP);
   assign bus.imemload = imemload_q;
   assign bus.dmemload = dmemload_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter : directed self-checking bench for mem_arbiter.             |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;
   logic clk;
   logic nrst;
   int   checks = 0;
   int   errors = 0;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle;
      bus.halt      = 1'b0;
      bus.imemREN   = 1'b0;
      bus.imemaddr  = '0;
      bus.dmemREN   = 1'b0;
      bus.dmemWEN   = 1'b0;
      bus.dmemaddr  = '0;
      bus.dmemstore = '0;
      bus.ramload   = '0;
      bus.ramrdy    = 1'b0;
   endtask

   task automatic test_reset;
      nrst = 1'b0;
      drive_idle();
      repeat (2) tick();
      checks++;
      if ({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN} !== 4'b0000)
         $display("FAIL reset_ctrl: got %b expected 0000", {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN});
      checks++;
      if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0)
         $display("FAIL reset_ram: got addr %h store %h expected 0 0", bus.ramaddr, bus.ramstore);
      checks++;
      if (bus.imemload !== 32'h0 || bus.dmemload !== 32'h0)
         $display("FAIL reset_load: got i %h d %h expected 0 0", bus.imemload, bus.dmemload);
      if (errors == 0 && ({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN} !== 4'b0000 ||
          bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0 || bus.imemload !== 32'h0 || bus.dmemload !== 32'h0))
         errors++;
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_single_fetch;
      int ren_cycles = 0;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h0;
      bus.ramrdy   = 1'b1;
      bus.ramload  = 32'h8C010004;
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (bus.ramREN) ren_cycles++;
         checks++;
         if (bus.ramWEN !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ramWEN c%0d: got %b expected 0", c, bus.ramWEN);
         end
         checks++;
         if (bus.ihit !== (c == 2)) begin
            errors++;
            $display("FAIL fetch_ihit c%0d: got %b expected %b", c, bus.ihit, (c == 2));
         end
         if (c == 2) begin
            checks++;
            if (bus.imemload !== 32'h8C010004) begin
               errors++;
               $display("FAIL fetch_load: got %h expected 8c010004", bus.imemload);
            end
            bus.imemREN = 1'b0;
         end
      end
      checks++;
      if (ren_cycles != 1) begin
         errors++;
         $display("FAIL fetch_ren_len: got %0d expected 1", ren_cycles);
      end
      drive_idle();
      tick();
   endtask

   task automatic test_write_wait;
      int hits = 0;
      bus.dmemWEN   = 1'b1;
      bus.dmemaddr  = 32'h100;
      bus.dmemstore = 32'hDEADBEEF;
      bus.ramrdy    = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 1) begin
            // latched request must ignore later input changes
            bus.dmemWEN   = 1'b0;
            bus.dmemaddr  = 32'h999;
            bus.dmemstore = 32'h0;
         end
         bus.ramrdy = (c == 4);
         if (bus.dhit) hits++;
         if (c <= 4) begin
            checks++;
            if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h100 || bus.ramstore !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL write_hold c%0d: got wen %b ren %b addr %h data %h expected 1 0 100 deadbeef",
                        c, bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore);
            end
         end else begin
            checks++;
            if (bus.ramWEN !== 1'b0) begin
               errors++;
               $display("FAIL write_wen_off c%0d: got %b expected 0", c, bus.ramWEN);
            end
         end
         checks++;
         if (bus.dhit !== (c == 5)) begin
            errors++;
            $display("FAIL write_dhit c%0d: got %b expected %b", c, bus.dhit, (c == 5));
         end
      end
      checks++;
      if (hits != 1) begin
         errors++;
         $display("FAIL write_dhit_count: got %0d expected 1", hits);
      end
      drive_idle();
      tick();
   endtask

   task automatic test_contention;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h10;
      bus.dmemREN  = 1'b1;
      bus.dmemaddr = 32'h20;
      bus.ramrdy   = 1'b1;
      bus.ramload  = 32'hABCD0000;
      for (int c = 1; c <= 12; c++) begin
         tick();
         checks++;
         if (bus.dhit !== (c == 2 || c == 8) || bus.ihit !== (c == 5 || c == 11)) begin
            errors++;
            $display("FAIL contention_order c%0d: got d %b i %b expected d %b i %b",
                     c, bus.dhit, bus.ihit, (c == 2 || c == 8), (c == 5 || c == 11));
         end
         if (c == 1 || c == 4 || c == 7 || c == 10) begin
            checks++;
            if (bus.ramaddr !== ((c == 1 || c == 7) ? 32'h20 : 32'h10)) begin
               errors++;
               $display("FAIL contention_addr c%0d: got %h expected %h",
                        c, bus.ramaddr, ((c == 1 || c == 7) ? 32'h20 : 32'h10));
            end
         end
         if (c == 3 || c == 6 || c == 9 || c == 12) begin
            checks++;
            if (dut.ifair_q !== (c == 3 || c == 9)) begin
               errors++;
               $display("FAIL contention_ifair c%0d: got %b expected %b", c, dut.ifair_q, (c == 3 || c == 9));
            end
         end
      end
      checks++;
      if (bus.dmemload !== 32'hABCD0000 || bus.imemload !== 32'hABCD0000) begin
         errors++;
         $display("FAIL contention_load: got d %h i %h expected abcd0000", bus.dmemload, bus.imemload);
      end
      drive_idle();
      tick();
   endtask

   task automatic test_halt;
      bus.halt     = 1'b1;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h30;
      bus.ramrdy   = 1'b1;
      bus.ramload  = 32'h77;
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++;
         if (bus.ramREN !== 1'b0 || bus.ihit !== 1'b0) begin
            errors++;
            $display("FAIL halt_fetch c%0d: got ren %b ihit %b expected 0 0", c, bus.ramREN, bus.ihit);
         end
      end
      bus.dmemREN  = 1'b1;
      bus.dmemaddr = 32'h200;
      bus.ramload  = 32'h5;
      tick();
      checks++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h200) begin
         errors++;
         $display("FAIL halt_dread_acc: got ren %b addr %h expected 1 200", bus.ramREN, bus.ramaddr);
      end
      tick();
      checks++;
      if (bus.dhit !== 1'b1 || bus.dmemload !== 32'h5) begin
         errors++;
         $display("FAIL halt_dread_hit: got dhit %b load %h expected 1 5", bus.dhit, bus.dmemload);
      end
      bus.dmemREN = 1'b0;
      tick();
      checks++;
      if (bus.ramREN !== 1'b0 || dut.ifair_q !== 1'b0) begin
         errors++;
         $display("FAIL halt_after: got ren %b ifair %b expected 0 0", bus.ramREN, dut.ifair_q);
      end
      drive_idle();
      tick();
   endtask

   task automatic test_reset_mid;
      bus.dmemREN  = 1'b1;
      bus.dmemaddr = 32'h300;
      bus.ramrdy   = 1'b0;
      tick();
      checks++;
      if (bus.ramREN !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: got ren %b expected 1", bus.ramREN);
      end
      #2 nrst = 1'b0;
      #1;
      checks++;
      if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit} !== 4'b0000 || bus.ramaddr !== 32'h0 ||
          bus.ramstore !== 32'h0 || bus.imemload !== 32'h0 || bus.dmemload !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_outputs: got ctrl %b addr %h store %h i %h d %h expected all 0",
                  {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}, bus.ramaddr, bus.ramstore, bus.imemload, bus.dmemload);
      end
      drive_idle();
      tick();
      nrst = 1'b1;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h4;
      bus.ramrdy   = 1'b1;
      bus.ramload  = 32'hCAFE;
      tick();
      checks++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h4 || bus.ihit !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_fetch_acc: got ren %b addr %h ihit %b expected 1 4 0", bus.ramREN, bus.ramaddr, bus.ihit);
      end
      tick();
      checks++;
      if (bus.ihit !== 1'b1 || bus.imemload !== 32'hCAFE) begin
         errors++;
         $display("FAIL rstmid_fetch_hit: got ihit %b load %h expected 1 cafe", bus.ihit, bus.imemload);
      end
      drive_idle();
      tick();
   endtask

`ifdef MEM_ARB_IBUF_EN
   task automatic test_ibuf;
      int ren = 0;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h40;
      bus.ramrdy   = 1'b1;
      bus.ramload  = 32'h1111;
      tick();
      tick();
      checks++;
      if (bus.ihit !== 1'b1 || bus.imemload !== 32'h1111) begin
         errors++;
         $display("FAIL ibuf_fill: got ihit %b load %h expected 1 1111", bus.ihit, bus.imemload);
      end
      bus.imemREN = 1'b0;
      tick();
      bus.imemREN = 1'b1;
      bus.ramload = 32'h2222;
      tick();
      checks++;
      if (bus.ihit !== 1'b1 || bus.imemload !== 32'h1111 || bus.ramREN !== 1'b0) begin
         errors++;
         $display("FAIL ibuf_hit: got ihit %b load %h ren %b expected 1 1111 0", bus.ihit, bus.imemload, bus.ramREN);
      end
      bus.imemREN   = 1'b0;
      tick();
      bus.dmemWEN   = 1'b1;
      bus.dmemaddr  = 32'h40;
      bus.dmemstore = 32'h0;
      tick();
      tick();
      checks++;
      if (bus.dhit !== 1'b1) begin
         errors++;
         $display("FAIL ibuf_write: got dhit %b expected 1", bus.dhit);
      end
      bus.dmemWEN = 1'b0;
      tick();
      bus.imemREN = 1'b1;
      bus.ramload = 32'h3333;
      tick();
      if (bus.ramREN) ren++;
      checks++;
      if (bus.ihit !== 1'b0 || ren != 1) begin
         errors++;
         $display("FAIL ibuf_inval_acc: got ihit %b ren %0d expected 0 1", bus.ihit, ren);
      end
      tick();
      checks++;
      if (bus.ihit !== 1'b1 || bus.imemload !== 32'h3333) begin
         errors++;
         $display("FAIL ibuf_inval_hit: got ihit %b load %h expected 1 3333", bus.ihit, bus.imemload);
      end
      drive_idle();
      tick();
   endtask
`endif

   initial begin
      nrst = 1'b0;
      drive_idle();
      test_reset();
      test_single_fetch();
      test_write_wait();
      test_contention();
      test_halt();
      test_reset_mid();
`ifdef MEM_ARB_IBUF_EN
      test_ibuf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
